addsub_byte_seq: RTL and testbench



---
 rtl/addsub_pkg.sv | 28 ++
 rtl/addsub8_slice.sv | 36 +++
 rtl/addsub_byte_seq.sv | 169 ++++++++++++++++
 tb/tb_addsub_byte_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types and constants for the byte-serial add/subtract sequencer.
//   state_t  : sequencer FSM states (IDLE, RUN, DONE)
//   BYTE_W   : width of one datapath slice
//   OP_ADD / OP_SUB : encoding of the op_sub input
//   nbytes() : number of byte slices needed for a given operand width
// ---------------------------------------------------------------------------
package addsub_pkg;

   localparam int BYTE_W = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of byte passes for an operand of the given width. The width is
   // expected to be a whole number of bytes.
   function automatic int nbytes(input int width);
      return width / BYTE_W;
   endfunction

endpackage

// File: rtl/addsub8_slice.sv
// ---------------------------------------------------------------------------
// addsub8_slice
// Purely combinational 8-bit add/subtract slice.
//   a, b  : byte operands
//   inv   : when 1, b is one's-complemented before the add (subtract mode)
//   cin   : carry in from the previous byte
//   sum   : 8-bit result byte
//   cout  : carry out of bit 7
//   c7    : carry into bit 7, used for signed overflow detection
// ---------------------------------------------------------------------------
module addsub8_slice
   import addsub_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              inv,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout,
   output logic              c7
);

   logic [BYTE_W-1:0] b_eff;
   logic [BYTE_W-1:0] low;
   logic [1:0]        high;

   // The add is split at bit 7 so the carry into the MSB is available on its
   // own; the upper stage is a single-bit full adder fed by that carry.
   assign b_eff = b ^ {BYTE_W{inv}};
   assign low   = {1'b0, a[BYTE_W-2:0]} + {1'b0, b_eff[BYTE_W-2:0]} + {{(BYTE_W-1){1'b0}}, cin};
   assign c7    = low[BYTE_W-1];
   assign high  = {1'b0, a[BYTE_W-1]} + {1'b0, b_eff[BYTE_W-1]} + {1'b0, c7};
   assign sum   = {high[0], low[BYTE_W-2:0]};
   assign cout  = high[1];

endmodule

// File: rtl/addsub_byte_seq.sv
// ---------------------------------------------------------------------------
// addsub_byte_seq
// Byte-serial WIDTH-bit add/subtract sequencer. One addsub8_slice is reused
// for every byte, with the carry chained through a register between passes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   op_a, op_b, op_sub  : operands and operation (1 = A-B, 0 = A+B)
//   out_valid/out_ready : result handshake (valid held until accepted)
//   result, cout        : registered sum/difference and final carry
//   ovf, zero, neg      : status flags
// Build option: define ADDSUB_FLAGS_EN to generate ovf/zero/neg; otherwise
// they are tied to 0.
// ---------------------------------------------------------------------------
module addsub_byte_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int NBYTES = nbytes(WIDTH);
   localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   state_t                        state_q, state_d;
   logic [NBYTES-1:0][BYTE_W-1:0] a_q, a_d;
   logic [NBYTES-1:0][BYTE_W-1:0] b_q, b_d;
   logic [NBYTES-1:0][BYTE_W-1:0] res_q, res_d;
   logic                          sub_q, sub_d;
   logic                          carry_q, carry_d;
   logic                          cout_q, cout_d;
   logic [IDXW-1:0]               idx_q, idx_d;

   logic [BYTE_W-1:0] slice_sum;
   logic              slice_cout;
   logic              slice_c7;
   logic              last_byte;

   // The single slice always looks at the byte selected by the index; its
   // output only matters while the FSM is in RUN.
   addsub8_slice u_slice (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .inv  (sub_q),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout),
      .c7   (slice_c7)
   );

   assign last_byte = (state_q == RUN) && (idx_q == LAST_IDX);

   // Next-state and datapath update. Everything holds by default; IDLE
   // captures a new operand set, RUN writes one result byte per cycle, and
   // DONE waits for the consumer to take the result.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               sub_d   = op_sub;
               carry_d = (op_sub == OP_SUB);
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[idx_q] = slice_sum;
            carry_d      = slice_cout;
            idx_d        = idx_q + 1'b1;
            if (last_byte) begin
               cout_d  = slice_cout;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = res_q;
   assign cout      = cout_q;

`ifdef ADDSUB_FLAGS_EN
   logic ovf_q, zero_q, neg_q;

   // Flags are captured together with the final byte, so they describe the
   // complete result for the whole time DONE is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (last_byte) begin
         ovf_q  <= slice_c7 ^ slice_cout;
         zero_q <= (res_d == '0);
         neg_q  <= slice_sum[BYTE_W-1];
      end
   end

   assign ovf  = ovf_q;
   assign zero = zero_q;
   assign neg  = neg_q;
`else
   logic unused_c7;

   // Without flag support the MSB carry has no consumer.
   assign unused_c7 = slice_c7;
   assign ovf       = 1'b0;
   assign zero      = 1'b0;
   assign neg       = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_byte_seq.sv
// ---------------------------------------------------------------------------
// tb_addsub_byte_seq
// Directed self-checking bench for addsub_byte_seq (WIDTH = 32). Expected
// flag values follow the ADDSUB_FLAGS_EN build option.
// ---------------------------------------------------------------------------
module tb_addsub_byte_seq;

   localparam int W  = 32;
   localparam int NB = 4;

`ifdef ADDSUB_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;
   logic         neg;

   int checks   = 0;
   int failures = 0;

   addsub_byte_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one complete operation with hand-computed expectations: accept,
   // count the latency, check the result and flags, then handshake it out.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input logic ez, input logic en, input string nm);
      int lat;
      lat = 0;
      while (!in_ready && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL %s_ready: got %b expected 1", nm, in_ready);
      end
      op_a     = a;
      op_b     = b;
      op_sub   = sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (lat !== NB) begin
         failures++;
         $display("[TB] FAIL %s_latency: got %0d expected %0d", nm, lat, NB);
      end
      checks++;
      if (result !== er) begin
         failures++;
         $display("[TB] FAIL %s_result: got %h expected %h", nm, result, er);
      end
      checks++;
      if (cout !== ec) begin
         failures++;
         $display("[TB] FAIL %s_cout: got %b expected %b", nm, cout, ec);
      end
      checks++;
      if (ovf !== (FLAGS_ON & eo)) begin
         failures++;
         $display("[TB] FAIL %s_ovf: got %b expected %b", nm, ovf, FLAGS_ON & eo);
      end
      checks++;
      if (zero !== (FLAGS_ON & ez)) begin
         failures++;
         $display("[TB] FAIL %s_zero: got %b expected %b", nm, zero, FLAGS_ON & ez);
      end
      checks++;
      if (neg !== (FLAGS_ON & en)) begin
         failures++;
         $display("[TB] FAIL %s_neg: got %b expected %b", nm, neg, FLAGS_ON & en);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL %s_release: got valid=%b ready=%b expected valid=0 ready=1",
                  nm, out_valid, in_ready);
      end
   endtask

   // Reset state after a clean power-up reset.
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_handshake: got ready=%b valid=%b expected ready=1 valid=0",
                  in_ready, out_valid);
      end
      checks++;
      if ({result, cout, ovf, zero, neg} !== {W'(0), 4'b0000}) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got result=%h flags=%b expected 0", result,
                  {cout, ovf, zero, neg});
      end
   endtask

   // Arithmetic vectors including carry chaining across byte boundaries,
   // borrows, signed overflow and zero detection.
   task automatic test_arith();
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, "add_ff_1");
      run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, "sub_0_1");
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf");
      run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, "sub_zero");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, "add_max");
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, "sub_ovf");
      run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0, 1'b0, "add_chain");
   endtask

   // Result must hold steady while the consumer stalls, and operand traffic
   // during the stall must be ignored.
   task automatic test_backpressure();
      int lat;
      op_a     = 32'h1234_5678;
      op_b     = 32'h1111_1111;
      op_sub   = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid;
         op_a     = $urandom;
         op_b     = $urandom;
         op_sub   = ~op_sub;
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h2345_6789 || cout !== 1'b0
             || ovf !== 1'b0 || zero !== 1'b0 || neg !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold%0d: got valid=%b ready=%b result=%h flags=%b expected 1 0 23456789 0000",
                     i, out_valid, in_ready, result, {cout, ovf, zero, neg});
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1",
                  out_valid, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_idle: got valid=%b ready=%b expected valid=0 ready=1",
                  out_valid, in_ready);
      end
   endtask

   // Reset in the middle of RUN discards the partial result; the next
   // operation must start from a clean carry and index.
   task automatic test_reset_mid_run();
      op_a     = 32'h0101_0101;
      op_b     = 32'h0101_0101;
      op_sub   = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0
          || {cout, ovf, zero, neg} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL rst_mid: got ready=%b valid=%b result=%h flags=%b expected 1 0 0 0000",
                  in_ready, out_valid, result, {cout, ovf, zero, neg});
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_no_valid%0d: got %b expected 0", i, out_valid);
         end
      end
      run_op(32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0, "sub_after_rst");
   endtask

   // Continuous traffic with an always-ready consumer: one operation every
   // NB+2 cycles, with no acceptance in the DONE->IDLE cycle.
   task automatic test_back_to_back();
      logic exp_ready;
      logic exp_valid;
      op_a      = 32'h0000_0001;
      op_b      = 32'h0000_0002;
      op_sub    = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         exp_ready = ((e % (NB + 2)) == 0);
         exp_valid = ((e % (NB + 2)) == NB + 1);
         if (e == 12) begin
            in_valid = 1'b0;
         end
         checks++;
         if (in_ready !== exp_ready || out_valid !== exp_valid) begin
            failures++;
            $display("[TB] FAIL b2b_e%0d: got ready=%b valid=%b expected ready=%b valid=%b",
                     e, in_ready, out_valid, exp_ready, exp_valid);
         end
         if (exp_valid) begin
            checks++;
            if (result !== 32'h0000_0003) begin
               failures++;
               $display("[TB] FAIL b2b_result_e%0d: got %h expected 00000003", e, result);
            end
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_sub    = 1'b0;
      out_ready = 1'b0;
      $display("[TB] starting addsub_byte_seq bench, flags build=%0d", FLAGS_ON);
      test_reset();
      test_arith();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
